// File: rtl/dcache_refill_pkg.sv
// Shared definitions for the data-cache miss-refill controller.
// State encoding and line geometry defaults.
package dcache_refill_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DEF_MEM_SCALE = 27;
    localparam int DEF_LINE_LOG  = 2;
    localparam int LINE_WORDS     = 2 ** DEF_LINE_LOG;
    localparam int LINE_BYTES_LOG = DEF_LINE_LOG + 2;

endpackage

// File: rtl/dcache_refill.sv
// Miss-refill controller: fetches a line from DRAM as a beat burst and
// streams it into the cache fill port, yielding to processor writes.
module dcache_refill
    import dcache_refill_pkg::*;
#(
    parameter int MEM_SCALE = DEF_MEM_SCALE,
    parameter int LINE_LOG  = DEF_LINE_LOG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_valid,
    input  logic [MEM_SCALE-1:0] miss_addr,
    input  logic [3:0]           cpu_we,
    output logic                 busy,
    output logic                 refill_done,
    output logic                 mem_req,
    output logic [MEM_SCALE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic                 mem_rvalid,
    input  logic [31:0]          mem_rdata,
    output logic                 mem_rready,
    output logic                 load_oe,
    output logic [MEM_SCALE-1:0] load_addr,
    output logic [31:0]          load_wdata,
    output logic [3:0]           load_we
);

    localparam int LB_LOG = LINE_LOG + 2;

    state_t               state, state_nx;
    logic [LINE_LOG-1:0]  cnt, cnt_nx;
    logic [MEM_SCALE-1:0] base, base_nx;
    logic                 accept;

    logic unused_bits;
    assign unused_bits = ^{cpu_we[3:1], miss_addr[LB_LOG-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            base  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            base  <= base_nx;
        end
    end

    assign mem_addr = base;
    assign accept   = (state == S_FILL) && mem_rvalid && mem_rready;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        base_nx     = base;
        busy        = 1'b0;
        refill_done = 1'b0;
        mem_req     = 1'b0;
        mem_rready  = 1'b0;
        load_oe     = 1'b0;
        load_we     = 4'h0;
        load_addr   = '0;
        load_wdata  = '0;
        case (state)
            S_IDLE: begin
                // Stray beats from an interrupted burst are drained here.
                mem_rready = 1'b1;
                if (miss_valid) begin
                    base_nx  = {miss_addr[MEM_SCALE-1:LB_LOG],
                                {LB_LOG{1'b0}}};
                    cnt_nx   = '0;
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) state_nx = S_FILL;
            end
            S_FILL: begin
                busy       = 1'b1;
                mem_rready = !cpu_we[0];
                if (accept) begin
                    load_oe    = 1'b1;
                    load_we    = 4'hF;
                    load_addr  = base + (MEM_SCALE)'({cnt, 2'b00});
                    load_wdata = mem_rdata;
                    cnt_nx     = cnt + 1'b1;
                    if (&cnt) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                refill_done = 1'b1;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_refill.sv
// Randomized self-checking bench for dcache_refill against a
// line/beat-level reference model.
module tb_dcache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0;
    logic [26:0] miss_addr = '0;
    logic [3:0]  cpu_we = '0;
    logic        busy, refill_done, mem_req, mem_rready, load_oe;
    logic [26:0] mem_addr, load_addr;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] load_wdata;
    logic [3:0]  load_we;

    int vectors = 0;
    int errors  = 0;

    dcache_refill #(.MEM_SCALE(27), .LINE_LOG(2)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_addr(miss_addr),
        .cpu_we(cpu_we),
        .busy(busy), .refill_done(refill_done),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_rready(mem_rready),
        .load_oe(load_oe), .load_addr(load_addr),
        .load_wdata(load_wdata), .load_we(load_we)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        vectors++;
        if (!rst && load_we[0] && cpu_we[0]) begin
            errors++;
            $display("FAIL conflict: load_we=%b cpu_we=%b both bit0 high",
                     load_we, cpu_we);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        @(negedge clk);
        vectors++;
        if ({busy, refill_done, mem_req, load_oe, mem_rready} !== 5'b00001 ||
            mem_addr !== 27'h0 || load_we !== 4'h0 ||
            load_addr !== 27'h0 || load_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b req=%b oe=%b rr=%b ma=%h we=%h la=%h wd=%h want 0,0,0,0,1,0,0,0,0",
                     busy, refill_done, mem_req, load_oe, mem_rready,
                     mem_addr, load_we, load_addr, load_wdata);
        end
        tick;
        rst = 1'b0;
    endtask

    // One complete refill; the model is just: base = addr & ~15,
    // beat k lands at base+4k, accepted iff rvalid and no cpu write.
    task automatic run_refill(input logic [26:0] addr, input int ack_dly,
                              input int gap_pct, input int cpu_pct,
                              input int hold_beat, input int hold_len,
                              input int cpu_beat, input bit extra_miss,
                              input bit fixed_data);
        logic [26:0] base;
        logic [31:0] data [4];
        logic [2:0]  hi;
        int k, obs_writes, held, budget;
        bit acc, cpu0, cpu_done;
        base = addr & ~27'hF;
        for (int i = 0; i < 4; i++)
            data[i] = fixed_data ? 32'hA0 + 32'(i) : $urandom;
        miss_valid = 1'b1;
        miss_addr  = addr;
        cpu_we     = 4'h0;
        mem_rvalid = 1'b0;
        mem_ack    = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_before: busy=%b req=%b want 0,0", busy, mem_req);
        end
        tick;
        miss_valid = 1'b0;
        for (int i = 0; i <= ack_dly; i++) begin
            mem_ack = (i == ack_dly);
            @(negedge clk);
            vectors++;
            if ({busy, mem_req, mem_rready, load_oe} !== 4'b1100 ||
                mem_addr !== base) begin
                errors++;
                $display("FAIL req: busy/req/rr/oe=%b%b%b%b addr=%h want 1100 %h",
                         busy, mem_req, mem_rready, load_oe, mem_addr, base);
            end
            tick;
        end
        mem_ack = 1'b0;
        k = 0; obs_writes = 0; held = 0; budget = 0; cpu_done = 0;
        while (k < 4 && budget < 300) begin
            budget++;
            miss_valid = extra_miss && ($urandom_range(1) == 1);
            miss_addr  = 27'($urandom);
            mem_rdata  = data[k];
            if (k == hold_beat && held < hold_len) begin
                mem_rvalid = 1'b0;
                held++;
            end else begin
                mem_rvalid = (int'($urandom_range(99)) >= gap_pct);
            end
            if (k == cpu_beat && !cpu_done && mem_rvalid) begin
                cpu0 = 1'b1;
                cpu_done = 1'b1;
            end else begin
                cpu0 = (int'($urandom_range(99)) < cpu_pct);
            end
            hi = 3'($urandom_range(7));
            cpu_we = {hi, cpu0};
            acc = mem_rvalid && !cpu0;
            @(negedge clk);
            vectors++;
            if (mem_rready !== !cpu0 || busy !== 1'b1 ||
                mem_req !== 1'b0 || refill_done !== 1'b0) begin
                errors++;
                $display("FAIL fill_ctl: rr=%b busy=%b req=%b done=%b want %b,1,0,0",
                         mem_rready, busy, mem_req, refill_done, !cpu0);
            end
            vectors++;
            if (load_we !== (acc ? 4'hF : 4'h0) || load_oe !== acc) begin
                errors++;
                $display("FAIL fill_we: we=%h oe=%b want %h %b beat %0d",
                         load_we, load_oe, acc ? 4'hF : 4'h0, acc, k);
            end
            if (load_we === 4'hF) obs_writes++;
            if (acc) begin
                vectors++;
                if (load_addr !== base + 27'(4 * k) || load_wdata !== data[k]) begin
                    errors++;
                    $display("FAIL fill_data: addr=%h data=%h want %h %h",
                             load_addr, load_wdata, base + 27'(4 * k), data[k]);
                end
                k++;
            end
            tick;
        end
        if (k < 4) begin
            errors++;
            $display("FAIL timeout: only %0d of 4 beats accepted", k);
        end
        mem_rvalid = 1'b0;
        cpu_we     = 4'h0;
        miss_valid = extra_miss;
        miss_addr  = 27'($urandom);
        @(negedge clk);
        vectors++;
        if ({refill_done, busy, load_oe, mem_rready, mem_req} !== 5'b11000) begin
            errors++;
            $display("FAIL done: done/busy/oe/rr/req=%b%b%b%b%b want 11000",
                     refill_done, busy, load_oe, mem_rready, mem_req);
        end
        tick;
        miss_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, refill_done, mem_req, mem_rready} !== 4'b0001) begin
            errors++;
            $display("FAIL after_done: busy/done/req/rr=%b%b%b%b want 0001",
                     busy, refill_done, mem_req, mem_rready);
        end
        vectors++;
        if (obs_writes != 4) begin
            errors++;
            $display("FAIL write_count: %0d fill writes, want 4", obs_writes);
        end
        tick;
    endtask

    task automatic test_basic;
        run_refill(27'h0001234, 3, 0, 0, -1, 0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_cpu_conflict;
        run_refill(27'h0001234, 3, 0, 0, -1, 0, 2, 1'b0, 1'b1);
    endtask

    task automatic test_rvalid_gap;
        run_refill(27'h0001234, 1, 0, 0, 2, 5, -1, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_miss;
        run_refill(27'h0ABCDE8, 2, 30, 0, -1, 0, -1, 1'b1, 1'b0);
    endtask

    task automatic test_top_addr;
        run_refill(27'h7FFFFFC, 0, 20, 20, -1, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        miss_valid = 1'b1;
        miss_addr  = 27'($urandom);
        tick;
        miss_valid = 1'b0;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            @(negedge clk);
            vectors++;
            if (load_we !== 4'hF) begin
                errors++;
                $display("FAIL pre_rst_beat: we=%h want f", load_we);
            end
            tick;
        end
        mem_rvalid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            @(negedge clk);
            vectors++;
            if ({busy, mem_req, mem_rready, load_oe} !== 4'b0010 ||
                load_we !== 4'h0) begin
                errors++;
                $display("FAIL post_rst_drain: busy/req/rr/oe=%b%b%b%b we=%h want 0010 0",
                         busy, mem_req, mem_rready, load_oe, load_we);
            end
            tick;
        end
        mem_rvalid = 1'b0;
        run_refill(27'h0345678, 1, 10, 10, -1, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 25; n++)
            run_refill(27'($urandom), int'($urandom_range(4)),
                       int'($urandom_range(50)), int'($urandom_range(40)),
                       -1, 0, -1, 1'($urandom_range(1)), 1'b0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_cpu_conflict;
        test_rvalid_gap;
        test_ignore_miss;
        test_reset_mid;
        test_top_addr;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dcache_refill.md
Name: dcache_refill

Overview:
- Miss-refill controller directly upstream of the data cache's load (fill) port.
- On a reported read miss it fetches the aligned line containing the miss address from DRAM as a burst of 32-bit beats.
- It streams each beat into the cache's load_oe/load_addr/load_wdata/load_we port and flags completion to pipeline stall logic.
- It guarantees the cache never sees a fill write and a processor write in the same cycle.

Parameters:
- MEM_SCALE, 27, byte-address width shared with the cache and DRAM.
- LINE_LOG, 2, log2 of words per line; a line is 2**LINE_LOG words = 4*2**LINE_LOG bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss_valid  in  1  one-cycle request: processor read missed
- miss_addr  in  MEM_SCALE  byte address of the missing access
- cpu_we  in  4  processor write byte-enables into the cache this cycle; only bit 0 is examined
- busy  out  1  refill in progress; miss_valid is ignored while high
- refill_done  out  1  one-cycle pulse after the last beat has been written
- mem_req  out  1  DRAM burst request
- mem_addr  out  MEM_SCALE  line-aligned burst address
- mem_ack  in  1  DRAM accepted the request
- mem_rvalid  in  1  DRAM read beat valid
- mem_rdata  in  32  DRAM read beat data
- mem_rready  out  1  refill accepts the beat this cycle
- load_oe  out  1  cache fill port enable
- load_addr  out  MEM_SCALE  fill word byte address
- load_wdata  out  32  fill data
- load_we  out  4  fill byte-enables

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, beat counter=0, line base=0.
  - busy=0, refill_done=0, mem_req=0, mem_addr=0.
  - load_oe=0, load_we=0, load_addr=0, load_wdata=0.
  - mem_rready=1 (IDLE drain, see below).
- States:
  - IDLE: busy=0. On miss_valid, latch base = miss_addr with bits [LINE_LOG+1:0] cleared, set beat counter=0, go to REQ.
  - REQ: busy=1, mem_req=1, mem_addr=base; both are held stable until mem_ack. On mem_ack go to FILL. mem_req is 0 from the cycle after the ack.
  - FILL: busy=1.
    - mem_rready = !cpu_we[0], combinational.
    - Beat accepted when mem_rvalid && mem_rready. In that cycle (combinational, same cycle):
      - load_oe=1
      - load_we=4'b1111
      - load_addr = base + {counter, 2'b00}
      - load_wdata = mem_rdata
    - Otherwise load_we=0 and load_oe=0.
    - Counter increments per accepted beat. The accept with counter == 2**LINE_LOG-1 moves to DONE.
  - DONE: busy=1, refill_done=1 for exactly one cycle, then IDLE.
- Latency:
  - miss_valid to mem_req: 1 cycle.
  - Last fill write to refill_done: 1 cycle. The cache's registered hit therefore reflects the full line by the time refill_done is seen.
- Conflict rule: load_we[0] and cpu_we[0] are never both high in the same cycle. A beat offered while cpu_we[0]=1 is held by DRAM (rvalid/rready handshake) and written in a later cycle.
- Beats are written in ascending word order. Addresses never cross the line boundary; the counter is exactly LINE_LOG bits and wraps to 0 on DONE.
- miss_valid while busy (REQ/FILL/DONE) is ignored and not queued. A miss coincident with refill_done is also ignored; the stall logic re-issues it.
- mem_rvalid outside FILL: mem_rready=1 in IDLE (stray beats left by a reset mid-burst are drained and discarded, load_we stays 0). mem_rready=0 in REQ and DONE.
- Reset mid-operation: the FSM returns to IDLE next edge and no further fill writes occur. A partially filled line is left as-is; cache valid bits are per-word, so stale words stay correct.
- mem_ack in IDLE/FILL/DONE is ignored.

Decomposition:
- Shared header (alongside UTIL.v):
  - state encodings IDLE/REQ/FILL/DONE (2 bits)
  - localparam LINE_WORDS = 2**LINE_LOG
  - localparam LINE_BYTES_LOG = LINE_LOG+2
- No sub-module; FSM, counter and address generation stay in one module.

Test Plan:
- Miss at 0x0001234 (LINE_LOG=2). mem_ack after 3 cycles. 4 back-to-back beats 0xA0..0xA3 → mem_addr=0x0001230. Fill writes to 0x1230/0x1234/0x1238/0x123C with load_we=1111 in consecutive cycles. refill_done one cycle after the last write; busy falls with it.
- Same refill with cpu_we=0001 during beat 2 → mem_rready=0 that cycle, no load_we. Beat 2 is written the next cycle. Assert load_we[0]&cpu_we[0] never both high.
- DRAM holds rvalid low for 5 cycles between beats 1 and 2 → counter and load_addr hold. Exactly 4 writes total; refill_done timing relative to the last write unchanged.
- Second miss_valid during FILL and during DONE → ignored: no second mem_req, and state returns to IDLE after one refill.
- rst asserted after 2 beats accepted → next cycle busy=0, mem_req=0. Remaining 2 DRAM beats accepted with rready=1 and no load_we. A new miss then issues a fresh mem_req.
- Miss at 0x7FFFFFC (top of address space) → mem_addr=0x7FFFFF0. Fill addresses 0x7FFFFF0..0x7FFFFFC with no wrap past the line.
